// File: rtl/instr_mem_fetch.sv
// Program-loadable instruction memory with a fixed-latency valid/ready fetch port.
// Misaligned or out-of-range fetches complete normally but return a faulted NOP.
module instr_mem_fetch #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_fault,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic [3:0]        ld_be,
  output logic              busy
);

  localparam int              IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] BYTE_LIMIT = (ADDR_W+1)'(4 * DEPTH_WORDS);
  localparam logic [31:0]     NOP        = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_rsp_data;
  logic              r_rsp_fault;
  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              w_accept;
  logic              w_enter_resp;
  logic [ADDR_W-1:0] w_fetch_addr;
  logic              w_fetch_fault;
  logic [31:0]       w_fetch_word;
  logic              w_ld_do;

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} >= BYTE_LIMIT;
  endfunction

  assign w_accept = req_valid && req_ready;

  // With no wait cycles RESP is entered on the accept edge, before r_addr is loaded.
  assign w_fetch_addr  = (r_state == IDLE) ? req_addr : r_addr;
  assign w_fetch_fault = (w_fetch_addr[1:0] != 2'b00) || out_of_range(w_fetch_addr);
  assign w_fetch_word  = r_mem[w_fetch_addr[IDX_W+1:2]];
  assign w_enter_resp  = (w_state_nxt == RESP) && (r_state != RESP);

  assign w_ld_do = ld_en && (r_state == IDLE) && !out_of_range(ld_addr);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (r_cnt <= 4'd1) w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    unique case (r_state)
      IDLE: begin
        req_ready = !ld_en;
        busy      = 1'b0;
      end
      WAIT:    ;
      RESP:    rsp_valid = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= 4'd0;
      r_addr      <= '0;
      r_rsp_data  <= 32'd0;
      r_rsp_fault <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr <= req_addr;
        r_cnt  <= 4'(WAIT_CYCLES);
      end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp) begin
        r_rsp_data  <= w_fetch_fault ? NOP : w_fetch_word;
        r_rsp_fault <= w_fetch_fault;
      end
    end
  end

  // NOTE: the array has no reset; program contents must survive rst.
  always_ff @(posedge clk) begin
    if (w_ld_do) begin
      for (int i = 0; i < 4; i++) begin
        if (ld_be[i]) r_mem[ld_addr[IDX_W+1:2]][8*i +: 8] <= ld_data[8*i +: 8];
      end
    end
  end

  assign rsp_data  = r_rsp_data;
  assign rsp_fault = r_rsp_fault;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Self-checking bench for instr_mem_fetch: table vectors, corner-case sequences and
// random traffic checked against a byte-array reference model.
module tb_instr_mem_fetch;

  localparam int    DEPTH  = 1024;
  localparam int    WAITC  = 2;
  localparam int    NBYTES = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_addr = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_fault;
  logic        ld_en = 1'b0;
  logic [31:0] ld_addr = '0, ld_data = '0;
  logic [3:0]  ld_be = '0;
  logic        busy;

  logic        d0_req_valid = 1'b0, d0_req_ready;
  logic [31:0] d0_req_addr = '0;
  logic        d0_rsp_valid, d0_rsp_ready = 1'b0;
  logic [31:0] d0_rsp_data;
  logic        d0_rsp_fault;
  logic        d0_ld_en = 1'b0;
  logic [31:0] d0_ld_addr = '0, d0_ld_data = '0;
  logic [3:0]  d0_ld_be = '0;
  logic        d0_busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] mbytes [NBYTES];

  always #5 clk = ~clk;

  instr_mem_fetch #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_be(ld_be), .busy(busy)
  );

  instr_mem_fetch #(.ADDR_W(32), .DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(d0_req_valid), .req_ready(d0_req_ready), .req_addr(d0_req_addr),
    .rsp_valid(d0_rsp_valid), .rsp_ready(d0_rsp_ready), .rsp_data(d0_rsp_data),
    .rsp_fault(d0_rsp_fault),
    .ld_en(d0_ld_en), .ld_addr(d0_ld_addr), .ld_data(d0_ld_data), .ld_be(d0_ld_be),
    .busy(d0_busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } load_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_data;
    logic        exp_fault;
  } fetch_t;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", nm, got, exp);
    end
  endtask

  function automatic void model_fetch(input logic [31:0] a, output logic [31:0] d,
                                      output logic f);
    if (a % 4 != 0 || a >= NBYTES) begin
      d = 32'h0000_0013;
      f = 1'b1;
    end else begin
      d = {mbytes[a+3], mbytes[a+2], mbytes[a+1], mbytes[a]};
      f = 1'b0;
    end
  endfunction

  task automatic do_load(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                         input logic with_req);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d; ld_be = be;
    req_valid = with_req; req_addr = a;
    #1 check("load req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    ld_en = 1'b0; req_valid = 1'b0;
    check("load busy", {31'd0, busy}, 32'd0);
    if (a < NBYTES) begin
      for (int i = 0; i < 4; i++) if (be[i]) mbytes[(a / 4) * 4 + i] = d[8*i +: 8];
    end
  endtask

  task automatic do_fetch(input string nm, input logic [31:0] a, input int hold,
                          input logic [31:0] ed, input logic ef);
    int n;
    logic [31:0] held;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; rsp_ready = 1'b0;
    #1 check({nm, " req_ready"}, {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, " latency"}, 32'(n), 32'(1 + WAITC));
    check({nm, " data"}, rsp_data, ed);
    check({nm, " fault"}, {31'd0, rsp_fault}, {31'd0, ef});
    held = rsp_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({nm, " hold valid"}, {31'd0, rsp_valid}, 32'd1);
      check({nm, " hold data"}, rsp_data, held);
      check({nm, " hold req_ready"}, {31'd0, req_ready}, 32'd0);
      check({nm, " hold busy"}, {31'd0, busy}, 32'd1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({nm, " done valid"}, {31'd0, rsp_valid}, 32'd0);
    check({nm, " done busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic fetch_model(input string nm, input logic [31:0] a, input int hold);
    logic [31:0] ed;
    logic ef;
    model_fetch(a, ed, ef);
    do_fetch(nm, a, hold, ed, ef);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    load_t  loads [5];
    fetch_t fvec  [9];
    int seen;

    loads[0] = '{32'h0000_0000, 32'h00A0_0213, 4'hF};
    loads[1] = '{32'h0000_0004, 32'h1122_3344, 4'hF};
    loads[2] = '{32'h0000_000A, 32'hDEAD_BEEF, 4'b0101};
    loads[3] = '{32'h0000_0FFC, 32'hCAFE_F00D, 4'hF};
    loads[4] = '{32'h0000_1000, 32'h5555_5555, 4'hF};

    fvec[0] = '{32'h0000_0000, 32'h00A0_0213, 1'b0};
    fvec[1] = '{32'h0000_0002, 32'h0000_0013, 1'b1};
    fvec[2] = '{32'h0000_1000, 32'h0000_0013, 1'b1};
    fvec[3] = '{32'h0000_0004, 32'h1122_3344, 1'b0};
    fvec[4] = '{32'h0000_0008, 32'h00AD_00EF, 1'b0};
    fvec[5] = '{32'h0000_0FFC, 32'hCAFE_F00D, 1'b0};
    fvec[6] = '{32'h0000_0FFF, 32'h0000_0013, 1'b1};
    fvec[7] = '{32'hFFFF_FFFC, 32'h0000_0013, 1'b1};
    fvec[8] = '{32'h0000_0010, 32'h0000_0000, 1'b0};

    for (int i = 0; i < NBYTES; i++) mbytes[i] = 8'h00;

    // Reset state
    #1;
    check("rst req_ready", {31'd0, req_ready}, 32'd1);
    check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst rsp_data", rsp_data, 32'd0);
    check("rst rsp_fault", {31'd0, rsp_fault}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // rsp_ready while idle must do nothing
    @(negedge clk);
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("idle rsp_ready valid", {31'd0, rsp_valid}, 32'd0);
    check("idle rsp_ready busy", {31'd0, busy}, 32'd0);
    rsp_ready = 1'b0;

    for (int i = 0; i < 5; i++) do_load(loads[i].addr, loads[i].data, loads[i].be, 1'b0);
    for (int i = 0; i < 9; i++)
      do_fetch($sformatf("vec%0d", i), fvec[i].addr, 0, fvec[i].exp_data, fvec[i].exp_fault);

    // Load beats a simultaneous fetch request; single byte lane merge
    do_load(32'h4, 32'hAABB_CCDD, 4'b0010, 1'b1);
    do_fetch("merge", 32'h4, 0, 32'h1122_CC44, 1'b0);

    // Long backpressure
    do_fetch("hold5", 32'h0, 5, 32'h00A0_0213, 1'b0);

    // Load while busy is dropped
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h8;
    @(negedge clk);
    req_valid = 1'b0;
    ld_en = 1'b1; ld_addr = 32'h8; ld_data = 32'hFFFF_FFFF; ld_be = 4'hF;
    #1 check("busy load req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    ld_en = 1'b0;
    seen = 0;
    while (!rsp_valid && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    check("busy load rsp", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    do_fetch("busy load kept", 32'h8, 0, 32'h00AD_00EF, 1'b0);

    // Reset during WAIT aborts the fetch
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort in wait", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort rsp_data", rsp_data, 32'd0);
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | int'(rsp_valid);
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | int'(rsp_valid);
    end
    check("abort no response", 32'(seen), 32'd0);
    do_fetch("after abort", 32'h0, 0, 32'h00A0_0213, 1'b0);

    // Zero-wait build: back-to-back fetches, one per two cycles
    @(negedge clk);
    d0_ld_en = 1'b1; d0_ld_addr = 32'h8; d0_ld_data = 32'h1234_5678; d0_ld_be = 4'hF;
    @(negedge clk);
    d0_ld_en = 1'b0;
    d0_req_valid = 1'b1; d0_req_addr = 32'h8; d0_rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("w0 valid k%0d", k), {31'd0, d0_rsp_valid}, {31'd0, k[0]});
      check($sformatf("w0 ready k%0d", k), {31'd0, d0_req_ready}, {31'd0, ~k[0]});
      if (k[0]) check($sformatf("w0 data k%0d", k), d0_rsp_data, 32'h1234_5678);
      @(negedge clk);
    end
    d0_req_valid = 1'b0; d0_rsp_ready = 1'b0;
    @(negedge clk);
    check("w0 idle", {31'd0, d0_busy}, 32'd0);

    // Random traffic against the byte model
    for (int it = 0; it < 60; it++) begin
      logic [31:0] a;
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 4) begin
        a = (kind == 0) ? 32'(NBYTES + $urandom_range(0, 255)) : 32'($urandom_range(0, 127));
        do_load(a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end else begin
        if (kind == 4)      a = 32'($urandom_range(0, 127));
        else if (kind == 5) a = 32'(NBYTES + 4 * $urandom_range(0, 63));
        else                a = 32'(4 * $urandom_range(0, 31));
        fetch_model($sformatf("rand%0d", it), a, $urandom_range(0, 3));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
